serial_sub: RTL and testbench

- Bit-serial two's-complement subtractor: computes diff = a - b - borrow, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flop.
- Inverse arithmetic companion to the team's adder cells.
- Serves area-constrained datapaths that accept WIDTH+1 cycle latency in exchange for one subtractor cell.

---
 rtl/serial_sub.sv | 146 ++++++++++++++
 tb/tb_serial_sub.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, diff = a - b - borrow.
// One full-subtractor cell plus a borrow flop; LSB first, one bit per clock.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf_out.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             borrow_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   // Holds the WIDTH-1 low result bits; the MSB is appended on the final step.
   logic [WIDTH-2:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] shifted;
   logic             last_bit;

   // The single full-subtractor cell operating on the current LSBs.
   always_comb begin
      d_bit    = a_q[0] ^ b_q[0] ^ br_q;
      br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      shifted  = {d_bit, res_q};
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   // Next-state and datapath control; every register holds by default.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_in) begin
               a_d     = a_in;
               b_d     = b_in;
               br_d    = borrow_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = shifted[WIDTH-1:1];
            br_d  = br_nxt;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
               // shifted is the completed result: new MSB over the low bits.
               diff_d  = shifted;
               bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
               // Borrow into the MSB stage vs. borrow out of it.
               ovf_d   = br_q ^ br_nxt;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; synchronous reset wins over everything.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Status decodes straight from the state register.
   always_comb begin
      busy_out   = (state_q != IDLE);
      done_out   = (state_q == DONE);
      diff_out   = diff_q;
      borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_out    = ovf_q;
`endif
   end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub (WIDTH=8): scoreboard of expected results, one task per scenario.
module tb_serial_sub;

   typedef struct {
      logic [7:0] d;
      logic       b;
      logic       o;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a_in, b_in;
   logic       bin;
   logic       busy, done;
   logic [7:0] diff;
   logic       bout;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   serial_sub #(.WIDTH(8)) dut (
      .clk_in    (clk),
      .rst_n_in  (rst_n),
      .start_in  (start),
      .a_in      (a_in),
      .b_in      (b_in),
      .borrow_in (bin),
      .busy_out  (busy),
      .done_out  (done),
      .diff_out  (diff),
      .borrow_out(bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf_out   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one start pulse and push the expected result.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi);
      exp_t       e;
      logic [8:0] r;
      @(posedge clk); #1;
      a_in  = a;
      b_in  = b;
      bin   = bi;
      start = 1'b1;
      r   = {1'b0, a} - {1'b0, b} - {8'd0, bi};
      e.d = r[7:0];
      e.b = r[8];
      e.o = (a[7] != b[7]) && (r[7] != a[7]);
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done; report cycles since the start edge.
   task automatic wait_done(output int cyc, output logic got);
      got = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = i;
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b1;   // start during reset must be lost
      a_in  = 8'h55;
      b_in  = 8'h11;
      bin   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_status busy=%b done=%b expected 0 0", busy, done);
      end
      checks++;
      if (diff !== 8'h00 || bout !== 1'b0) begin
         errors++;
         $display("FAIL reset_result diff=%h borrow=%b expected 00 0", diff, bout);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf ovf=%b expected 0", ovf);
      end
`endif
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_start_lost busy=%b expected 0", busy);
      end
   endtask

   task automatic test_basic;
      int   busy_cnt = 0;
      int   done_cnt = 0;
      int   cyc = 0;
      exp_t e;
      issue(8'h50, 8'h20, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            cyc = i;
         end
      end
      checks++;
      if (cyc != 9 || done_cnt != 1) begin
         errors++;
         $display("FAIL basic_latency cycle=%0d pulses=%0d expected 9 1", cyc, done_cnt);
      end
      checks++;
      if (busy_cnt != 9) begin
         errors++;
         $display("FAIL basic_busy cycles=%0d expected 9", busy_cnt);
      end
      e = sb.pop_front();
      checks++;
      if (diff !== e.d || bout !== e.b || diff !== 8'h30 || bout !== 1'b0) begin
         errors++;
         $display("FAIL basic_result diff=%h borrow=%b expected %h %b", diff, bout, e.d, e.b);
      end
   endtask

   // Borrow cases and (with the macro) overflow cases, all through the scoreboard.
   task automatic test_borrow_ovf;
      logic [7:0] ta[6];
      logic [7:0] tb[6];
      logic       tc[6];
      int         cyc;
      logic       got;
      exp_t       e;
      ta = '{8'h20, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h10};
      tb = '{8'h50, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'h05};
      tc = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
      for (int k = 0; k < 6; k++) begin
         issue(ta[k], tb[k], tc[k]);
         wait_done(cyc, got);
         e = sb.pop_front();
         checks++;
         if (!got || cyc != 9) begin
            errors++;
            $display("FAIL borrow_latency case=%0d got=%b cycle=%0d expected 9", k, got, cyc);
         end
         checks++;
         if (diff !== e.d || bout !== e.b) begin
            errors++;
            $display("FAIL borrow_result case=%0d diff=%h borrow=%b expected %h %b",
                     k, diff, bout, e.d, e.b);
         end
`ifdef SERIAL_SUB_OVF_EN
         checks++;
         if (ovf !== e.o) begin
            errors++;
            $display("FAIL ovf case=%0d ovf=%b expected %b", k, ovf, e.o);
         end
`endif
      end
   endtask

   task automatic test_start_while_busy;
      int         done_cnt = 0;
      logic [7:0] seen = 8'hxx;
      int         cyc;
      logic       got;
      exp_t       e;
      issue(8'h50, 8'h20, 1'b0);
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            seen = diff;
         end
         start = (i == 3 || i == 9);
         a_in  = 8'h01;
         b_in  = 8'h01;
      end
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL busy_start_pulses count=%0d expected 1", done_cnt);
      end
      checks++;
      if (seen !== e.d) begin
         errors++;
         $display("FAIL busy_start_result diff=%h expected %h", seen, e.d);
      end
      issue(8'h01, 8'h01, 1'b0);
      wait_done(cyc, got);
      e = sb.pop_front();
      checks++;
      if (!got || diff !== e.d || bout !== e.b) begin
         errors++;
         $display("FAIL busy_start_next got=%b diff=%h borrow=%b expected %h %b",
                  got, diff, bout, e.d, e.b);
      end
   endtask

   task automatic test_reset_mid_run;
      int   cyc;
      logic got;
      int   done_cnt = 0;
      exp_t e;
      issue(8'h50, 8'h20, 1'b0);
      wait_done(cyc, got);
      e = sb.pop_front();
      checks++;
      if (!got || diff !== e.d) begin
         errors++;
         $display("FAIL midrun_first got=%b diff=%h expected %h", got, diff, e.d);
      end
      issue(8'h20, 8'h50, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      void'(sb.pop_back());   // aborted operation never completes
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset busy=%b done=%b diff=%h borrow=%b expected 0 0 00 0",
                  busy, done, diff, bout);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL midrun_no_done pulses=%0d expected 0", done_cnt);
      end
      issue(8'h09, 8'h04, 1'b0);
      wait_done(cyc, got);
      e = sb.pop_front();
      checks++;
      if (!got || cyc != 9 || diff !== e.d || bout !== e.b) begin
         errors++;
         $display("FAIL midrun_fresh got=%b cycle=%0d diff=%h borrow=%b expected 9 %h %b",
                  got, cyc, diff, bout, e.d, e.b);
      end
   endtask

   task automatic test_back_to_back;
      int   cyc;
      logic got;
      exp_t e;
      for (int k = 0; k < 10; k++) begin
         issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         wait_done(cyc, got);
         e = sb.pop_front();
         checks++;
         if (!got || diff !== e.d || bout !== e.b) begin
            errors++;
            $display("FAIL random k=%0d got=%b diff=%h borrow=%b expected %h %b",
                     k, got, diff, bout, e.d, e.b);
         end
`ifdef SERIAL_SUB_OVF_EN
         checks++;
         if (ovf !== e.o) begin
            errors++;
            $display("FAIL random_ovf k=%0d ovf=%b expected %b", k, ovf, e.o);
         end
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      bin   = 1'b0;
      test_reset();
      test_basic();
      test_borrow_ovf();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
